regfile_mp: RTL

Parametrised multi-port integer register file with a per-register busy scoreboard. It is the next generation of the core's two-read/one-write register file. It provides NUM_RD read ports and NUM_WR write ports, optional same-cycle write-to-read bypass, and a busy bit per register for long-latency producers (load, multiply/divide). ID reads operands and busy flags, ID sets busy on issue, and WB writes results and clears busy.

---
 rtl/regfile_mp.sv | 77 +++++++
 1 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with per-register busy scoreboard
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic [NUM_WR-1:0]        wr_clr_i,
  input  logic                     set_en_i,
  input  logic [ADDR_W-1:0]        set_addr_i,
  output logic [(1<<ADDR_W)-1:0]   busy_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DEPTH-1:0]             busy_q;
  logic [DEPTH-1:0]             busy_d;
  logic [DEPTH-1:0]             clr_hit;

  // Ascending port order lets the higher-index writer decide the clear; set beats clear.
  always_comb begin
    clr_hit = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w]) clr_hit[wr_addr_i[w*ADDR_W +: ADDR_W]] = wr_clr_i[w];
    end
    busy_d = busy_q & ~clr_hit;
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] != '0))
          mem_q[wr_addr_i[w*ADDR_W +: ADDR_W]] <= wr_data_i[w*DATA_W +: DATA_W];
      end
    end
  end

  // Bypass loop runs in ascending order so the highest-index matching writer is forwarded.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rstn && rd_en_i[k] && (rd_addr_i[k*ADDR_W +: ADDR_W] != '0)) begin
        rd_data_o[k*DATA_W +: DATA_W] = mem_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
        rd_busy_o[k] = busy_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
        if (BYPASS != 0) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] == rd_addr_i[k*ADDR_W +: ADDR_W])) begin
              rd_data_o[k*DATA_W +: DATA_W] = wr_data_i[w*DATA_W +: DATA_W];
              rd_busy_o[k] = busy_q[rd_addr_i[k*ADDR_W +: ADDR_W]] & ~wr_clr_i[w];
            end
          end
        end
      end
    end
  end

  assign busy_o = busy_q;

endmodule
